bc_datapath: RTL

BC_DATAPATH -- requirements
Module: bc_datapath

---
 rtl/bc_datapath.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bc_datapath.sv
// bc_datapath -- basic-computer register/bus datapath.
// Registers AR, PC, DR, AC, IR, TR and E share one combinational common bus,
// an asynchronous-read word memory addressed by AR, and an accumulator ALU.
// Optional build macro: BC_PROTOCOL_CHK_EN enables a sticky control-protocol
// checker on ERR; without it ERR is tied low. The checker never alters the datapath.
module bc_datapath #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [2:0]       BUS_SEL,
    input  logic [19:0]      CTRL,
    input  logic [2:0]       ALU_OP,
    output logic [WIDTH-1:0] IR,
    output logic             CO,
    output logic             OVF,
    output logic             Z,
    output logic             N,
    output logic             E_IN,
    output logic             ERR
);

    typedef enum logic [2:0] {
        SRC_AR  = 3'b000,
        SRC_PC  = 3'b001,
        SRC_DR  = 3'b010,
        SRC_AC  = 3'b011,
        SRC_IR  = 3'b100,
        SRC_TR  = 3'b101,
        SRC_MEM = 3'b110,
        SRC_NONE = 3'b111
    } bus_src_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_XFER  = 3'b010,
        ALU_CMA   = 3'b011,
        ALU_CIL   = 3'b100,
        ALU_CIR   = 3'b101,
        ALU_PASS0 = 3'b110,
        ALU_PASS1 = 3'b111
    } alu_op_e;

    logic [ADDR_W-1:0] ar, pc;
    logic [WIDTH-1:0]  dr, ac, tr;
    logic              e_reg, zsrc;
    logic [WIDTH-1:0]  mem [2**ADDR_W];

    logic [WIDTH-1:0]  bus;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_e;
    logic              alu_sets_e;
    logic [WIDTH:0]    sum_ext;
    logic              ac_ld_eff;

    bus_src_e src;
    alu_op_e  op;

    assign src = bus_src_e'(BUS_SEL);
    assign op  = alu_op_e'(ALU_OP);

    // CTRL[17] is a reserved control with no function.
    logic unused_ctrl;
    assign unused_ctrl = CTRL[17];

    // Common bus multiplexer; 12-bit sources are zero-extended, memory read is asynchronous.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        bus = '0;
        unique case (src)
            SRC_AR:   bus = {{(WIDTH-ADDR_W){1'b0}}, ar};
            SRC_PC:   bus = {{(WIDTH-ADDR_W){1'b0}}, pc};
            SRC_DR:   bus = dr;
            SRC_AC:   bus = ac;
            SRC_IR:   bus = IR;
            SRC_TR:   bus = tr;
            SRC_MEM:  bus = mem[ar];
            SRC_NONE: bus = '0;
        endcase
    end

    // Accumulator ALU: result plus the E value produced by ADD/CIL/CIR.
    always_comb begin
        sum_ext    = {1'b0, ac} + {1'b0, dr};
        alu_res    = ac;
        alu_e      = e_reg;
        alu_sets_e = 1'b0;
        unique case (op)
            ALU_ADD:  begin alu_res = sum_ext[WIDTH-1:0]; alu_e = sum_ext[WIDTH]; alu_sets_e = 1'b1; end
            ALU_AND:  alu_res = ac & dr;
            ALU_XFER: alu_res = dr;
            ALU_CMA:  alu_res = ~ac;
            ALU_CIL:  begin alu_res = {ac[WIDTH-2:0], e_reg}; alu_e = ac[WIDTH-1]; alu_sets_e = 1'b1; end
            ALU_CIR:  begin alu_res = {e_reg, ac[WIDTH-1:1]}; alu_e = ac[0];       alu_sets_e = 1'b1; end
            ALU_PASS0, ALU_PASS1: alu_res = ac;
        endcase
    end

    // An AC load only counts when AC clear does not override it.
    assign ac_ld_eff = CTRL[9] & ~CTRL[11];

    // Register file update: per register CLR > LD > INR, all using pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (RST) begin
            ar    <= '0;
            pc    <= '0;
            dr    <= '0;
            ac    <= '0;
            IR    <= '0;
            tr    <= '0;
            e_reg <= 1'b0;
            CO    <= 1'b0;
            OVF   <= 1'b0;
            zsrc  <= 1'b0;
        end else begin
            if (CTRL[2])       ar <= '0;
            else if (CTRL[0])  ar <= bus[ADDR_W-1:0];
            else if (CTRL[1])  ar <= ar + ADDR_W'(1);

            if (CTRL[5])       pc <= '0;
            else if (CTRL[3])  pc <= bus[ADDR_W-1:0];
            else if (CTRL[4])  pc <= pc + ADDR_W'(1);

            if (CTRL[8])       dr <= '0;
            else if (CTRL[6])  dr <= bus;
            else if (CTRL[7])  dr <= dr + WIDTH'(1);

            if (CTRL[11])      ac <= '0;
            else if (CTRL[9])  ac <= alu_res;
            else if (CTRL[10]) ac <= ac + WIDTH'(1);

            if (CTRL[12])      IR <= bus;

            if (CTRL[15])      tr <= '0;
            else if (CTRL[13]) tr <= bus;
            else if (CTRL[14]) tr <= tr + WIDTH'(1);

            if (CTRL[19])                     e_reg <= 1'b0;
            else if (CTRL[18])                e_reg <= ~e_reg;
            else if (ac_ld_eff && alu_sets_e) e_reg <= alu_e;

            if (ac_ld_eff && op == ALU_ADD) begin
                CO  <= sum_ext[WIDTH];
                OVF <= (ac[WIDTH-1] == dr[WIDTH-1]) && (sum_ext[WIDTH-1] != ac[WIDTH-1]);
            end

            if (|CTRL[8:6])        zsrc <= 1'b1;
            else if (|CTRL[11:9])  zsrc <= 1'b0;
        end
    end

    // Memory write of the bus value at pre-edge AR; reset blocks the write.
    always_ff @(posedge clk) begin
        // NOTE: memory contents are deliberately not reset; only the write is suppressed.
        if (!RST && CTRL[16]) mem[ar] <= bus;
    end

    assign Z    = ((zsrc ? dr : ac) == '0);
    assign N    = ac[WIDTH-1];
    assign E_IN = e_reg;

`ifdef BC_PROTOCOL_CHK_EN
    function automatic logic multi_hot(input logic [2:0] t);
        return (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
    endfunction

    logic err_evt;

    // Protocol violations seen on this edge.
    always_comb begin
        err_evt = multi_hot(CTRL[2:0]) | multi_hot(CTRL[5:3]) | multi_hot(CTRL[8:6])
                | multi_hot(CTRL[11:9]) | multi_hot(CTRL[15:13])
                | ((src == SRC_NONE) && |{CTRL[0], CTRL[3], CTRL[6], CTRL[9], CTRL[12], CTRL[13], CTRL[16]})
                | (CTRL[16] && (src == SRC_MEM));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (RST) ERR <= 1'b0;
        else     ERR <= ERR | err_evt;
    end
`else
    assign ERR = 1'b0;
`endif

endmodule
